// File: rtl/register_file_pkg.sv
// Shared definitions for the CPU register file.
// Provides the data width, register count, PC index, the bit offsets of the
// address fields packed into RSLCT, and the IR_CU select encodings.
package register_file_pkg;

  localparam int WIDTH   = 32;
  localparam int NREGS   = 16;
  localparam int PC_IDX  = 15;
  localparam int AW      = 4;
  localparam int RSLCT_W = 20;

  // Bit offsets of each 4-bit address field inside RSLCT
  localparam int RN_LSB  = 0;
  localparam int RM_LSB  = 4;
  localparam int RS_LSB  = 8;
  localparam int DIR_LSB = 12;
  localparam int DCU_LSB = 16;

  // IR_CU = 0 selects the IR destination and ALU data,
  // IR_CU = 1 selects the control-unit destination and memory data
  localparam logic IR_CU_IR = 1'b0;
  localparam logic IR_CU_CU = 1'b1;

  typedef logic [AW-1:0]    reg_addr_t;
  typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/rf_reg32.sv
// One 32-bit storage register with synchronous active-high reset and load.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous reset, clears the register
//   ld_i   - load enable, captures d_i when set
//   d_i    - data to load
//   q_o    - current register contents
module rf_reg32
  import register_file_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Storage: reset has priority over load
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (ld_i) begin
      q_q <= d_i;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/register_file.sv
// Sixteen-entry, 32-bit register file with R15 acting as the program counter.
// Ports:
//   Clk    - clock, all updates on the rising edge
//   RESET  - synchronous active-high reset, clears all registers
//   Rd     - ALU result write data (IR_CU = 0)
//   Mem    - memory read write data (IR_CU = 1)
//   Pcin   - next PC value, loaded into R15 by LOADPC
//   RSLCT  - packed selects: Rn, Rm, Rs, IR destination, CU destination
//   LOADPC - load Pcin into R15
//   LOAD   - write enable for the selected destination
//   IR_CU  - destination/data source select
//   Rn, Rm, Rs - combinational read ports
//   PCout  - contents of R15
module register_file #(
  parameter int WIDTH  = register_file_pkg::WIDTH,
  parameter int NREGS  = register_file_pkg::NREGS,
  parameter int PC_IDX = register_file_pkg::PC_IDX
) (
  input  logic             Clk,
  input  logic             RESET,
  input  logic [WIDTH-1:0] Rd,
  input  logic [WIDTH-1:0] Mem,
  input  logic [WIDTH-1:0] Pcin,
  input  logic [19:0]      RSLCT,
  input  logic             LOADPC,
  input  logic             LOAD,
  input  logic             IR_CU,
  output logic [WIDTH-1:0] Rn,
  output logic [WIDTH-1:0] Rm,
  output logic [WIDTH-1:0] Rs,
  output logic [WIDTH-1:0] PCout
);

  import register_file_pkg::*;

  logic [3:0]       dest_s;
  logic [WIDTH-1:0] wdata_s;
  logic [NREGS-1:0] ld_s;
  logic             pc_ld_s;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] regs_q [NREGS];

  // Destination field and write data are both steered by IR_CU
  always_comb begin
    dest_s  = RSLCT[DIR_LSB +: 4];
    wdata_s = Rd;
    if (IR_CU == IR_CU_CU) begin
      dest_s  = RSLCT[DCU_LSB +: 4];
      wdata_s = Mem;
    end else begin
      dest_s  = RSLCT[DIR_LSB +: 4];
      wdata_s = Rd;
    end
  end

  // 4-to-16 destination decoder gated by LOAD
  always_comb begin
    ld_s = '0;
    if (LOAD) begin
      ld_s[dest_s] = 1'b1;
    end else begin
      ld_s = '0;
    end
  end

  // R15 load: LOADPC overrides a LOAD aimed at R15
  always_comb begin
    pc_ld_s = ld_s[PC_IDX];
    pc_d    = wdata_s;
    if (LOADPC) begin
      pc_ld_s = 1'b1;
      pc_d    = Pcin;
    end else begin
      pc_ld_s = ld_s[PC_IDX];
      pc_d    = wdata_s;
    end
  end

  rf_reg32 u_r0  (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[0]),  .d_i(wdata_s), .q_o(regs_q[0]));
  rf_reg32 u_r1  (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[1]),  .d_i(wdata_s), .q_o(regs_q[1]));
  rf_reg32 u_r2  (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[2]),  .d_i(wdata_s), .q_o(regs_q[2]));
  rf_reg32 u_r3  (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[3]),  .d_i(wdata_s), .q_o(regs_q[3]));
  rf_reg32 u_r4  (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[4]),  .d_i(wdata_s), .q_o(regs_q[4]));
  rf_reg32 u_r5  (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[5]),  .d_i(wdata_s), .q_o(regs_q[5]));
  rf_reg32 u_r6  (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[6]),  .d_i(wdata_s), .q_o(regs_q[6]));
  rf_reg32 u_r7  (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[7]),  .d_i(wdata_s), .q_o(regs_q[7]));
  rf_reg32 u_r8  (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[8]),  .d_i(wdata_s), .q_o(regs_q[8]));
  rf_reg32 u_r9  (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[9]),  .d_i(wdata_s), .q_o(regs_q[9]));
  rf_reg32 u_r10 (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[10]), .d_i(wdata_s), .q_o(regs_q[10]));
  rf_reg32 u_r11 (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[11]), .d_i(wdata_s), .q_o(regs_q[11]));
  rf_reg32 u_r12 (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[12]), .d_i(wdata_s), .q_o(regs_q[12]));
  rf_reg32 u_r13 (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[13]), .d_i(wdata_s), .q_o(regs_q[13]));
  rf_reg32 u_r14 (.clk_i(Clk), .rst_i(RESET), .ld_i(ld_s[14]), .d_i(wdata_s), .q_o(regs_q[14]));
  rf_reg32 u_r15 (.clk_i(Clk), .rst_i(RESET), .ld_i(pc_ld_s),  .d_i(pc_d),    .q_o(regs_q[15]));

  // Combinational read ports, no write bypass
  assign Rn    = regs_q[RSLCT[RN_LSB +: 4]];
  assign Rm    = regs_q[RSLCT[RM_LSB +: 4]];
  assign Rs    = regs_q[RSLCT[RS_LSB +: 4]];
  assign PCout = regs_q[PC_IDX];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by
// randomized traffic, all checked against a behavioural array model.
module tb_register_file;

  logic        Clk;
  logic        RESET;
  logic [31:0] Rd;
  logic [31:0] Mem;
  logic [31:0] Pcin;
  logic [19:0] RSLCT;
  logic        LOADPC;
  logic        LOAD;
  logic        IR_CU;
  logic [31:0] Rn;
  logic [31:0] Rm;
  logic [31:0] Rs;
  logic [31:0] PCout;

  logic [31:0] mdl [16];
  int          vectors;
  int          miscompares;

  register_file dut (
    .Clk(Clk), .RESET(RESET), .Rd(Rd), .Mem(Mem), .Pcin(Pcin),
    .RSLCT(RSLCT), .LOADPC(LOADPC), .LOAD(LOAD), .IR_CU(IR_CU),
    .Rn(Rn), .Rm(Rm), .Rs(Rs), .PCout(PCout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reads(input string tag);
    logic [3:0] a_n;
    logic [3:0] a_m;
    logic [3:0] a_s;
    a_n = RSLCT[3:0];
    a_m = RSLCT[7:4];
    a_s = RSLCT[11:8];
    check({tag, ".Rn"}, Rn, mdl[a_n]);
    check({tag, ".Rm"}, Rm, mdl[a_m]);
    check({tag, ".Rs"}, Rs, mdl[a_s]);
    check({tag, ".PCout"}, PCout, mdl[15]);
  endtask

  // One clock edge: reference model applies the architectural write rules
  task automatic step(input string tag);
    logic [3:0] d;
    @(posedge Clk);
    if (RESET) begin
      for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
    end else begin
      if (LOAD) begin
        d = IR_CU ? RSLCT[19:16] : RSLCT[15:12];
        mdl[d] = IR_CU ? Mem : Rd;
      end
      if (LOADPC) mdl[15] = Pcin;
    end
    #1;
    check_reads(tag);
  endtask

  // Read every register on every port without clocking
  task automatic sweep(input string tag);
    logic [3:0] a;
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      RSLCT[3:0]  = a;
      RSLCT[7:4]  = a + 4'd1;
      RSLCT[11:8] = a + 4'd5;
      #1;
      check_reads(tag);
    end
  endtask

  task automatic idle();
    RESET  = 1'b0;
    LOAD   = 1'b0;
    LOADPC = 1'b0;
    IR_CU  = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
    Rd = 32'd0; Mem = 32'd0; Pcin = 32'd0; RSLCT = 20'd0;
    idle();

    // Reset
    RESET = 1'b1;
    RSLCT = 20'hCBA98;
    step("reset");
    check("reset.Rn_const", Rn, 32'd0);
    check("reset.PC_const", PCout, 32'd0);
    RESET = 1'b0;
    sweep("reset_sweep");

    // IR write to R0
    #1;
    IR_CU = 1'b0; LOAD = 1'b1; Rd = 32'd1; RSLCT = 20'h00000;
    step("ir_wr");
    check("ir_wr.Rn_const", Rn, 32'd1);
    LOAD = 1'b0;
    RSLCT = 20'h00002;
    #1;
    check("ir_rd.Rn_R2", Rn, 32'd0);
    check("ir_rd.Rm_R0", Rm, 32'd1);
    check("ir_rd.Rs_R0", Rs, 32'd1);

    // CU memory write to R7; IR destination field R3 must not change
    IR_CU = 1'b1; LOAD = 1'b1; Mem = 32'hDEADBEEF; Rd = 32'h12345678;
    RSLCT = 20'h73070;
    step("cu_wr");
    check("cu_wr.Rm_const", Rm, 32'hDEADBEEF);
    idle();
    RSLCT = 20'h00003;
    #1;
    check("cu_wr.R3_unchanged", Rn, 32'd0);

    // PC path and LOADPC priority over LOAD to R15
    LOADPC = 1'b1; Pcin = 32'h100;
    step("pc_ld");
    check("pc_ld.const", PCout, 32'h100);
    LOADPC = 1'b1; LOAD = 1'b1; IR_CU = 1'b0; Pcin = 32'h200; Rd = 32'h55;
    RSLCT = 20'h0F000;
    step("pc_prio");
    check("pc_prio.const", PCout, 32'h200);

    // LOADPC and LOAD to another register: both happen
    Pcin = 32'h300; Rd = 32'hA5A5; RSLCT = 20'h04004;
    step("pc_both");
    check("pc_both.R4", Rn, 32'hA5A5);
    check("pc_both.PC", PCout, 32'h300);
    idle();

    // Write all 16 registers with i+1
    for (int i = 0; i < 16; i++) begin
      LOAD = 1'b1; IR_CU = 1'b0; Rd = 32'(i + 1);
      RSLCT = {4'd0, 4'(i), 12'd0};
      step("wr_all");
    end
    idle();
    sweep("wr_all_sweep");
    check("wr_all.R15_const", PCout, 32'd16);

    // Randomized traffic, including occasional reset and held LOAD
    for (int n = 0; n < 400; n++) begin
      RESET  = ($urandom_range(0, 39) == 0);
      LOAD   = $urandom_range(0, 2) != 0;
      LOADPC = $urandom_range(0, 4) == 0;
      IR_CU  = $urandom_range(0, 1) == 1;
      Rd     = $urandom;
      Mem    = $urandom;
      Pcin   = $urandom;
      RSLCT  = 20'($urandom);
      step("rand");
    end
    idle();
    sweep("rand_sweep");

    // Reset priority over LOAD and LOADPC
    RESET = 1'b1; LOAD = 1'b1; LOADPC = 1'b1; IR_CU = 1'b0;
    Rd = 32'hFFFF_FFFF; Pcin = 32'h1234; RSLCT = 20'h05000;
    step("rst_prio");
    check("rst_prio.PC_const", PCout, 32'd0);
    idle();
    sweep("rst_prio_sweep");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
